// File: rtl/axi4_lite_master_pkg.sv
// Shared types and constants for the AXI4-Lite master: bus widths, response codes, FSM states.
package axi4_lite_master_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_WR_RESP  = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_RESP  = 3'd4
    } state_e;

    // Error responses are exactly the codes with bit[1] set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one CPU load/store into an AW/W/B or AR/R exchange.
// Every output is a flop; inputs only steer the next-state and next-output logic.
module axi4_lite_master
    import axi4_lite_master_pkg::*;
#(
    parameter int unsigned ADDR_W = AXI_ADDR_W,
    parameter int unsigned DATA_W = AXI_DATA_W
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                REQ_VALID,
    output logic                REQ_READY,
    input  logic                REQ_WE,
    input  logic [ADDR_W-1:0]   REQ_ADDR,
    input  logic [DATA_W-1:0]   REQ_WDATA,
    input  logic [DATA_W/8-1:0] REQ_WSTRB,
    output logic                RSP_VALID,
    output logic [DATA_W-1:0]   RSP_RDATA,
    output logic                RSP_ERR,
    output logic                AW_VALID,
    input  logic                AW_READY,
    output logic [ADDR_W-1:0]   AW_ADDR,
    output logic                W_VALID,
    input  logic                W_READY,
    output logic [DATA_W-1:0]   W_DATA,
    output logic [DATA_W/8-1:0] W_STRB,
    input  logic                B_VALID,
    output logic                B_READY,
    input  logic [1:0]          B_RESP,
    output logic                AR_VALID,
    input  logic                AR_READY,
    output logic [ADDR_W-1:0]   AR_ADDR,
    input  logic                R_VALID,
    output logic                R_READY,
    input  logic [DATA_W-1:0]   R_DATA,
    input  logic [1:0]          R_RESP
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_e state_q, state_d;

    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              aw_valid_q,  aw_valid_d;
    logic              w_valid_q,   w_valid_d;
    logic              b_ready_q,   b_ready_d;
    logic              ar_valid_q,  ar_valid_d;
    logic              r_ready_q,   r_ready_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [STRB_W-1:0] wstrb_q,     wstrb_d;

    // A channel is done once its VALID has been dropped or is being accepted this cycle.
    logic aw_done_c;
    logic w_done_c;
    assign aw_done_c = !aw_valid_q || AW_READY;
    assign w_done_c  = !w_valid_q  || W_READY;

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (REQ_VALID) state_d = REQ_WE ? ST_WR_ISSUE : ST_RD_ISSUE;
            ST_WR_ISSUE: if (aw_done_c && w_done_c) state_d = ST_WR_RESP;
            ST_WR_RESP:  if (B_VALID) state_d = ST_IDLE;
            ST_RD_ISSUE: if (AR_READY) state_d = ST_RD_RESP;
            ST_RD_RESP:  if (R_VALID) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the request latch
    always_comb begin
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        aw_valid_d  = 1'b0;
        w_valid_d   = 1'b0;
        b_ready_d   = 1'b0;
        ar_valid_d  = 1'b0;
        r_ready_d   = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    addr_d     = REQ_ADDR;
                    wdata_d    = REQ_WDATA;
                    wstrb_d    = REQ_WSTRB;
                    aw_valid_d = REQ_WE;
                    w_valid_d  = REQ_WE;
                    ar_valid_d = !REQ_WE;
                end
            end
            ST_WR_ISSUE: begin
                aw_valid_d = !aw_done_c;
                w_valid_d  = !w_done_c;
                b_ready_d  = aw_done_c && w_done_c;
            end
            ST_WR_RESP: begin
                b_ready_d = !B_VALID;
                if (B_VALID) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = resp_is_err(B_RESP);
                end
            end
            ST_RD_ISSUE: begin
                ar_valid_d = !AR_READY;
                r_ready_d  = AR_READY;
            end
            ST_RD_RESP: begin
                r_ready_d = !R_VALID;
                if (R_VALID) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = resp_is_err(R_RESP);
                    rsp_rdata_d = R_DATA;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers; REQ_READY comes out of reset high because the FSM is idle.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            b_ready_q   <= b_ready_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    assign REQ_READY = req_ready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_ERR   = rsp_err_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign AW_VALID  = aw_valid_q;
    assign AW_ADDR   = addr_q;
    assign W_VALID   = w_valid_q;
    assign W_DATA    = wdata_q;
    assign W_STRB    = wstrb_q;
    assign B_READY   = b_ready_q;
    assign AR_VALID  = ar_valid_q;
    assign AR_ADDR   = addr_q;
    assign R_READY   = r_ready_q;

endmodule
